// File: rtl/param_calculator.sv
// Parameterised accumulator-style calculator driven by a single step strobe.
// Operands are captured on rising edges of instrucao, a one-cycle EXEC state
// computes the result, and DONE either starts a fresh A/B pair or chains the
// previous result as the next A operand.
module param_calculator #(
    parameter int unsigned W     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     dados,
    input  logic             instrucao,
    input  logic [2:0]       op,
    input  logic             chain,
    output logic [W-1:0]     reg_a,
    output logic [W-1:0]     reg_b,
    output logic [W:0]       result,
    output logic             flag_zero,
    output logic             flag_neg,
    output logic             flag_ovf,
    output logic             fim,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWaitB = 2'd1;
    localparam logic [1:0] StExec  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     reg_a_q, reg_a_d;
    logic [W-1:0]     reg_b_q, reg_b_d;
    logic [W:0]       result_q, result_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic [2:0]       op_q, op_d;
    logic             chain_q, chain_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             instr_q;
    logic             step;

    logic [W:0]       opa, opb;
    logic [W+1:0]     sum_w;
    logic [W:0]       alu_res;
    logic             alu_ovf, alu_neg;

    // Rising edge of the strobe; instr_q resets high so a held level is not a step.
    assign step = instrucao & ~instr_q;

    // Combinational ALU on the registered operands and latched opcode.
    always_comb begin
        opa     = chain_q ? result_q : {1'b0, reg_a_q};
        opb     = {1'b0, reg_b_q};
        sum_w   = {1'b0, opa} + {1'b0, opb};
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_neg = 1'b0;
        case (op_q)
            3'd0: begin
                alu_res = sum_w[W:0];
                alu_ovf = sum_w[W+1];
            end
            3'd1: begin
                alu_res = opa - opb;
                alu_neg = (opa < opb);
            end
            3'd2: alu_res = opa & opb;
            3'd3: alu_res = opa | opb;
            3'd4: alu_res = opa ^ opb;
            3'd5: begin
                alu_res = {opa[W-1:0], 1'b0};
                alu_ovf = opa[W];
            end
            3'd6: alu_res = {1'b0, opa[W:1]};
            default: alu_res = opb;
        endcase
    end

    // Next-state logic for the FSM and all datapath registers.
    always_comb begin
        state_d  = state_q;
        reg_a_d  = reg_a_q;
        reg_b_d  = reg_b_q;
        result_d = result_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        op_d     = op_q;
        chain_d  = chain_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (step) begin
                    reg_a_d = dados;
                    chain_d = 1'b0;
                    state_d = StWaitB;
                end
            end
            StWaitB: begin
                if (step) begin
                    reg_b_d = dados;
                    op_d    = op;
                    state_d = StExec;
                end
            end
            StExec: begin
                result_d = alu_res;
                zero_d   = (alu_res == '0);
                neg_d    = alu_neg;
                ovf_d    = alu_ovf;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                state_d = StDone;
            end
            default: begin
                if (step) begin
                    if (chain) begin
                        reg_b_d = dados;
                        op_d    = op;
                        chain_d = 1'b1;
                        state_d = StExec;
                    end else begin
                        reg_a_d = dados;
                        chain_d = 1'b0;
                        state_d = StWaitB;
                    end
                end
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            op_q     <= '0;
            chain_q  <= 1'b0;
            cnt_q    <= '0;
            instr_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            reg_a_q  <= reg_a_d;
            reg_b_q  <= reg_b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            op_q     <= op_d;
            chain_q  <= chain_d;
            cnt_q    <= cnt_d;
            instr_q  <= instrucao;
        end
    end

    assign reg_a     = reg_a_q;
    assign reg_b     = reg_b_q;
    assign result    = result_q;
    assign flag_zero = zero_q;
    assign flag_neg  = neg_q;
    assign flag_ovf  = ovf_q;
    assign state     = state_q;
    assign fim       = (state_q == StDone);
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_param_calculator.sv
// Self-checking bench for param_calculator: directed scenarios plus random
// step sequences compared against a transaction-level arithmetic model.
module tb_param_calculator;

    localparam int unsigned W     = 4;
    localparam int unsigned CNT_W = 8;
    localparam int          MOD   = 1 << (W + 1);
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [W-1:0]     dados;
    logic             instrucao;
    logic [2:0]       op;
    logic             chain;
    logic [W-1:0]     reg_a;
    logic [W-1:0]     reg_b;
    logic [W:0]       result;
    logic             flag_zero;
    logic             flag_neg;
    logic             flag_ovf;
    logic             fim;
    logic [1:0]       state;
    logic [CNT_W-1:0] op_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: operation-level view of the calculator.
    int m_state, m_a, m_b, m_res, m_op, m_chain, m_cnt;
    int m_zero, m_neg, m_ovf;

    param_calculator #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .dados     (dados),
        .instrucao (instrucao),
        .op        (op),
        .chain     (chain),
        .reg_a     (reg_a),
        .reg_b     (reg_b),
        .result    (result),
        .flag_zero (flag_zero),
        .flag_neg  (flag_neg),
        .flag_ovf  (flag_ovf),
        .fim       (fim),
        .state     (state),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_state = 0; m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_chain = 0;
        m_cnt = 0; m_zero = 0; m_neg = 0; m_ovf = 0;
    endtask

    task automatic m_exec();
        int a, b, s;
        a = m_chain ? m_res : m_a;
        b = m_b;
        m_ovf = 0;
        m_neg = 0;
        case (m_op)
            0: begin s = a + b; m_res = s % MOD; m_ovf = (s >= MOD) ? 1 : 0; end
            1: begin m_neg = (a < b) ? 1 : 0; m_res = (a - b + MOD) % MOD; end
            2: m_res = a & b;
            3: m_res = a | b;
            4: m_res = a ^ b;
            5: begin m_ovf = (a >= MOD / 2) ? 1 : 0; m_res = (2 * a) % MOD; end
            6: m_res = a / 2;
            default: m_res = b;
        endcase
        m_zero = (m_res == 0) ? 1 : 0;
        if (m_cnt < CMAX) m_cnt++;
        m_state = 3;
    endtask

    task automatic m_step(input int d, input int o, input int c);
        case (m_state)
            0: begin m_a = d; m_chain = 0; m_state = 1; end
            1: begin m_b = d; m_op = o; m_state = 2; end
            3: begin
                if (c != 0) begin m_b = d; m_op = o; m_chain = 1; m_state = 2; end
                else begin m_a = d; m_chain = 0; m_state = 1; end
            end
            default: ;
        endcase
    endtask

    task automatic check_all();
        check_eq("state", int'(state), m_state);
        check_eq("fim", int'(fim), (m_state == 3) ? 1 : 0);
        check_eq("reg_a", int'(reg_a), m_a);
        check_eq("reg_b", int'(reg_b), m_b);
        check_eq("result", int'(result), m_res);
        check_eq("flag_zero", int'(flag_zero), m_zero);
        check_eq("flag_neg", int'(flag_neg), m_neg);
        check_eq("flag_ovf", int'(flag_ovf), m_ovf);
        check_eq("op_count", int'(op_count), m_cnt);
    endtask

    // One strobe pulse (one cycle high, one low); checks EXEC latency on the way.
    task automatic do_step(input int d, input int o, input int c);
        dados     = 4'(d);
        op        = 3'(o);
        chain     = 1'(c);
        instrucao = 1'b1;
        @(negedge clk);
        instrucao = 1'b0;
        m_step(d, o, c);
        if (m_state == 2) begin
            check_eq("exec_state", int'(state), 2);
            check_eq("exec_fim", int'(fim), 0);
            m_exec();
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        instrucao = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_reset();
    endtask

    initial begin
        dados     = '0;
        op        = '0;
        chain     = 1'b0;
        instrucao = 1'b1;
        rst       = 1'b1;
        m_reset();
        repeat (2) @(negedge clk);
        check_all();

        // Strobe held through reset release must not step.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("held_after_rst", int'(state), 0);
        instrucao = 1'b0;
        @(negedge clk);

        // ADD 9 + 7.
        do_step(9, 0, 0);
        do_step(7, 0, 0);
        check_eq("add_res", int'(result), 16);
        check_eq("add_ovf", int'(flag_ovf), 0);
        check_eq("add_fim", int'(fim), 1);
        check_eq("add_cnt", int'(op_count), 1);

        // Chained adds, wrapping to zero.
        do_step(15, 0, 1);
        check_eq("chain1_res", int'(result), 31);
        do_step(1, 0, 1);
        check_eq("chain2_res", int'(result), 0);
        check_eq("chain2_ovf", int'(flag_ovf), 1);
        check_eq("chain2_zero", int'(flag_zero), 1);

        // SUB 3 - 5 wraps with borrow.
        do_step(3, 0, 0);
        do_step(5, 1, 0);
        check_eq("sub_res", int'(result), 30);
        check_eq("sub_neg", int'(flag_neg), 1);
        check_eq("sub_zero", int'(flag_zero), 0);

        // Held strobe in IDLE gives exactly one transition.
        reset_dut();
        dados     = 4'd6;
        instrucao = 1'b1;
        repeat (10) @(negedge clk);
        m_step(6, 0, 0);
        check_eq("held_state", int'(state), 1);
        instrucao = 1'b0;
        @(negedge clk);
        check_all();

        // Reset abandons an operation in WAIT_B.
        reset_dut();
        do_step(9, 0, 0);
        check_eq("waitb_rega", int'(reg_a), 9);
        rst = 1'b1;
        #1;
        check_eq("rst_rega", int'(reg_a), 0);
        check_eq("rst_state", int'(state), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_reset();

        // 300 operations saturate the counter.
        do_step(int'($urandom_range(0, 15)), 0, 0);
        do_step(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), 0);
        for (int i = 0; i < 299; i++) begin
            do_step(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), 1);
        end
        check_eq("cnt_sat", int'(op_count), 255);

        // Random mix of steps, idle gaps and resets.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                reset_dut();
                check_all();
            end else if (r == 1) begin
                repeat (int'($urandom_range(1, 3))) @(negedge clk);
                check_all();
            end else begin
                do_step(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
